muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width (even, >= 8).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  request valid.
REQ-005 SHALL have port: in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port: funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port: a  input  XLEN  operand rs1.
REQ-008 SHALL have port: b  input  XLEN  operand rs2.
REQ-009 SHALL have port: flush  input  1  abort any in-flight operation.
REQ-010 SHALL have port: out_valid  output  1  result valid.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: result  output  XLEN  operation result.
REQ-013 SHALL have port: div_zero  output  1  divide/remainder op had b == 0; valid with out_valid.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-015 SHALL accept a request on a rising edge where in_valid && in_ready && !flush, capturing funct3, a and b.
REQ-016 SHALL drive in_ready = !flush && (state == IDLE || (state == DONE && out_ready)), giving back-to-back acceptance on result handoff.
REQ-017 SHALL compute all ops with one radix-2 iterative datapath: shift-add multiply, restoring divide on operand magnitudes, one bit per cycle.
REQ-018 SHALL run BUSY for exactly XLEN cycles, so out_valid first rises XLEN+1 cycles after the accept edge.
REQ-019 SHALL take signedness from funct3: MULH both signed, MULHSU a signed and b unsigned, MULHU/DIVU/REMU unsigned, MUL sign-agnostic low half.
REQ-020 SHALL negate the 2*XLEN product when operand signs differ, and select the low half for MUL and the high half otherwise.
REQ-021 SHALL give the signed quotient the sign of a XOR b, and the signed remainder the sign of a.
REQ-022 SHALL fast-path b == 0 (skipping BUSY, out_valid one cycle after accept): quotient all-ones, remainder = a, div_zero = 1.
REQ-023 SHALL fast-path signed overflow (DIV/REM with a = most-negative, b = -1), also one cycle: quotient = a, remainder = 0, div_zero = 0.
REQ-024 SHALL hold result, div_zero and out_valid stable in DONE until out_ready is high.
REQ-025 SHALL go to BUSY (or DONE for a fast path) on an accept in DONE with out_ready, otherwise to IDLE, when out_ready is high in DONE.
REQ-026 SHALL force the FSM to IDLE on flush high at any edge, dropping the operation without raising out_valid.
REQ-027 SHALL give flush priority over acceptance and over result handoff in the same cycle.
REQ-028 SHALL drive out_valid only in DONE and div_zero low outside DONE.

Reset
REQ-029 SHALL on rst_n low immediately set the FSM to IDLE and out_valid, div_zero, result and the iteration counter to 0.
REQ-030 SHALL have in_ready high in the first cycle after rst_n deasserts.
REQ-031 SHALL abandon any in-flight operation when rst_n asserts mid-operation, and never output its result.

Structure
REQ-032 SHALL place the funct3 op encodings and the FSM state enum in shared package muldiv_pkg.
REQ-033 SHALL use one sub-module, muldiv_sign, for operand absolute value and conditional result negation (combinational, XLEN-parametrised).
REQ-034 SHALL size the iteration counter at clog2(XLEN+1) bits.

Verification
REQ-035 SHALL cover, at XLEN=32: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid 33 cycles after accept.
REQ-036 SHALL cover: a=b=0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
REQ-037 SHALL cover: DIV a=5, b=0 -> 0xFFFFFFFF, and REM a=5, b=0 -> 0x00000005; both with div_zero=1 and out_valid one cycle after accept.
REQ-038 SHALL cover: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, and REM -> 0, both fast-path; DIV a=0xFFFFFFF9, b=2 -> 0xFFFFFFFD, and REM -> 0xFFFFFFFF.
REQ-039 SHALL cover: out_ready low 5 cycles in DONE -> result held constant; out_ready high with in_valid high -> new op accepted the same edge.
REQ-040 SHALL cover: flush at BUSY cycle 10 -> out_valid never rises, in_ready high next cycle; rst_n pulse mid-BUSY -> all outputs 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: the funct3 op
// encodings, the FSM state enum and small decode helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // MUL is sign-agnostic for its low half, so it is treated as unsigned.
    function automatic logic op_a_signed(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_MULHSU) || (f == OP_DIV) || (f == OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f);
        return (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_sign.sv
// Conditional two's-complement negation; serves both as operand absolute
// value (neg = sign bit of a signed operand) and as result sign fix-up.
module muldiv_sign #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with signs fixed up at the end.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            div_zero
);

    localparam int              CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state;
    logic [CW-1:0]       cnt;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     mc_q;
    logic [2*XLEN-1:0]   p_q;
    logic                neg_lo_q, neg_hi_q;
    logic [XLEN-1:0]     result_q;
    logic                dz_q;

    logic                accept, a_neg, b_neg, b_zero, ovf, fast;
    logic [XLEN-1:0]     a_mag, b_mag, fast_res;
    logic [XLEN:0]       mul_sum, shifted;
    logic [XLEN-1:0]     sub;
    logic                ge;
    logic [2*XLEN-1:0]   mul_next, div_next, p_next, prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, busy_res;

    // Handshake
    assign in_ready  = !flush && (state == ST_IDLE || (state == ST_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);
    assign div_zero  = out_valid && dz_q;
    assign result    = result_q;

    // Request decode and fast paths
    assign a_neg  = op_a_signed(funct3) && a[XLEN-1];
    assign b_neg  = op_b_signed(funct3) && b[XLEN-1];
    assign b_zero = (b == '0);
    assign ovf    = (funct3 == OP_DIV || funct3 == OP_REM) && (a == MOST_NEG) && (b == '1);
    assign fast   = funct3[2] && (b_zero || ovf);
    // funct3[1] separates remainder ops from quotient ops within the divide group.
    assign fast_res = b_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);

    muldiv_sign #(.W(XLEN)) u_abs_a (.val(a), .neg(a_neg), .res(a_mag));
    muldiv_sign #(.W(XLEN)) u_abs_b (.val(b), .neg(b_neg), .res(b_mag));

    // Multiply step: {hi, lo} holds partial product above the remaining multiplier bits.
    assign mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, mc_q} : '0);
    assign mul_next = {mul_sum, p_q[XLEN-1:1]};

    // Divide step: {hi, lo} holds partial remainder above the dividend/quotient bits.
    assign shifted  = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    assign ge       = (shifted >= {1'b0, mc_q});
    assign sub      = shifted[XLEN-1:0] - mc_q;
    assign div_next = ge ? {sub, p_q[XLEN-2:0], 1'b1}
                         : {shifted[XLEN-1:0], p_q[XLEN-2:0], 1'b0};

    assign p_next = op_q[2] ? div_next : mul_next;

    // Sign fix-up is applied to the final step's value so the result is
    // registered on the same edge that enters DONE.
    muldiv_sign #(.W(2*XLEN)) u_neg_p (.val(p_next),                 .neg(neg_lo_q), .res(prod_fix));
    muldiv_sign #(.W(XLEN))   u_neg_q (.val(p_next[XLEN-1:0]),       .neg(neg_lo_q), .res(quo_fix));
    muldiv_sign #(.W(XLEN))   u_neg_r (.val(p_next[2*XLEN-1:XLEN]),  .neg(neg_hi_q), .res(rem_fix));

    always_comb begin
        busy_res = quo_fix;
        case (op_q)
            OP_MUL:                       busy_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: busy_res = prod_fix[2*XLEN-1:XLEN];
            OP_REM, OP_REMU:              busy_res = rem_fix;
            default:                      busy_res = quo_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            op_q     <= '0;
            mc_q     <= '0;
            p_q      <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else if (accept) begin
            op_q     <= funct3;
            cnt      <= '0;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            if (fast) begin
                state    <= ST_DONE;
                result_q <= fast_res;
                dz_q     <= b_zero;
            end else begin
                state <= ST_BUSY;
                dz_q  <= 1'b0;
                p_q   <= {{XLEN{1'b0}}, funct3[2] ? a_mag : b_mag};
                mc_q  <= funct3[2] ? b_mag : a_mag;
            end
        end else begin
            case (state)
                ST_BUSY: begin
                    p_q <= p_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state    <= ST_DONE;
                        result_q <= busy_res;
                    end
                end
                ST_DONE: if (out_ready) state <= ST_IDLE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed corner cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_seq;

    localparam int XLEN     = 32;
    localparam int LAT_SLOW = XLEN + 1;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            in_valid = 1'b0, in_ready, flush = 1'b0;
    logic            out_valid, out_ready = 1'b1, div_zero;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] a = '0, b = '0, result;

    typedef struct {
        logic [31:0] res;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0, errors = 0, cyc = 0, rdy_mode = 0;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the op definitions, using wide arithmetic.
    function automatic void ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic dz, output int lat);
        longint sx, sy, ux, uy, q;
        logic [63:0] p;
        sx = longint'($signed(x)); sy = longint'($signed(y));
        ux = longint'({32'b0, x}); uy = longint'({32'b0, y});
        dz = 1'b0; lat = LAT_SLOW; r = '0;
        case (f)
            3'd0: begin p = ux * uy; r = p[31:0];  end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * uy; r = p[63:32]; end
            3'd3: begin p = ux * uy; r = p[63:32]; end
            3'd4, 3'd6: begin
                if (y == 0) begin
                    dz = 1'b1; lat = 1; r = (f == 3'd4) ? 32'hFFFF_FFFF : x;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    lat = 1; r = (f == 3'd4) ? x : 32'h0;
                end else begin
                    q = (f == 3'd4) ? sx / sy : sx % sy;
                    r = q[31:0];
                end
            end
            default: begin
                if (y == 0) begin
                    dz = 1'b1; lat = 1; r = (f == 3'd5) ? 32'hFFFF_FFFF : x;
                end else begin
                    r = (f == 3'd5) ? x / y : x % y;
                end
            end
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] er, input logic ed, input int el, output int waited);
        exp_t e;
        waited = 0;
        in_valid = 1'b1; funct3 = f; a = aa; b = bb;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                chk("accept_timeout", in_ready, 1);
                break;
            end
        end
        if (in_ready) begin
            e.res = er; e.dz = ed; e.acc = cyc + 1; e.lat = el;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_ref(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb);
        logic [31:0] r; logic dz; int lat, w;
        ref_op(f, aa, bb, r, dz, lat);
        issue(f, aa, bb, r, dz, lat, w);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((sbq.size() != 0 || out_valid) && t < 300) begin
            @(posedge clk); #1; t++;
        end
        chk(name, sbq.size(), 0);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the scoreboard on every handoff, checks first-rise latency and hold stability.
    initial begin
        exp_t e;
        logic prev_ov = 1'b0, prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin prev_ov = 1'b0; prev_hs = 1'b0; continue; end
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                    prev_hs = 1'b0;
                end else begin
                    if (!prev_ov || prev_hs)
                        chk("latency", 64'(cyc - sbq[0].acc + 1), 64'(sbq[0].lat));
                    else begin
                        chk("hold_result", result, sbq[0].res);
                        chk("hold_div_zero", div_zero, sbq[0].dz);
                    end
                    if (out_ready) begin
                        e = sbq.pop_front();
                        chk("result", result, e.res);
                        chk("div_zero", div_zero, e.dz);
                        prev_hs = 1'b1;
                    end else prev_hs = 1'b0;
                end
            end else begin
                chk("div_zero_idle", div_zero, 0);
                prev_hs = 1'b0;
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        int w;
        logic [2:0] f;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_div_zero", div_zero, 0);
        chk("rst_result", result, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed corner cases
        rdy_mode = 0;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, LAT_SLOW, w);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, LAT_SLOW, w);
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, LAT_SLOW, w);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, LAT_SLOW, w);
        issue(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, w);
        issue(3'b110, 32'd5, 32'd0, 32'h0000_0005, 1'b1, 1, w);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, w);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1, w);
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, LAT_SLOW, w);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, LAT_SLOW, w);
        drain("drain_directed");

        // Result held while out_ready is low, then handoff with same-edge accept
        rdy_mode = 2; out_ready = 1'b0;
        issue_ref(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (LAT_SLOW + 5) @(posedge clk);
        #1;
        rdy_mode = 0; out_ready = 1'b1;
        issue(3'b000, 32'd3, 32'd4, 32'd12, 1'b0, LAT_SLOW, w);
        chk("b2b_accept_wait", 64'(w), 0);
        drain("drain_hold");

        // Flush mid-BUSY, with a competing request while flush is high
        issue_ref(3'b000, 32'd123, 32'd456);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'b000; a = 32'd9; b = 32'd9;
        sbq.delete();
        @(negedge clk) chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_flush_in_ready", in_ready, 1);
        chk("post_flush_out_valid", out_valid, 0);
        repeat (LAT_SLOW + 8) @(posedge clk);
        #1;

        // Reset pulse mid-BUSY
        issue_ref(3'b101, 32'd1000, 32'd7);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_div_zero", div_zero, 0);
        chk("midrst_result", result, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("midrst_in_ready", in_ready, 1);
        repeat (LAT_SLOW + 4) @(posedge clk);
        #1;

        // Randomized ops with random consumer backpressure and gaps
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            issue_ref(f, rand_opnd(), rand_opnd());
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rdy_mode = 0;
        drain("drain_random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
